// File: rtl/btle_rx_frame_ctrl.sv
// BLE receive frame controller: assembles LSB-first octets after an access-address hit,
// parses the PDU length, runs the CRC-24 check and supervises the inter-bit gap.
module btle_rx_frame_ctrl #(
    parameter int unsigned LEN_WIDTH                = 8,
    parameter int unsigned MAX_PAYLOAD_LEN          = 255,
    parameter int unsigned TIMEOUT_CYCLES           = 64,
    parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                ext_len_en,
    input  logic [23:0]                         crc_state_init_bit,
    input  logic                                hit_flag,
    input  logic                                info_bit,
    input  logic                                bit_valid,
    output logic [7:0]                          octet,
    output logic                                octet_valid,
    output logic                                octet_sop,
    output logic                                octet_eop,
    output logic [LEN_WIDTH-1:0]                payload_length,
    output logic                                payload_length_valid,
    output logic                                busy,
    output logic                                decode_end,
    output logic                                crc_ok,
    output logic                                length_error,
    output logic                                timeout
);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StCrc} state_t;

    localparam int unsigned GAP_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [23:0] CRC_POLY  = 24'h00065B;

    state_t                r_state,        w_state_d;
    logic [7:0]            r_octet_sr,     w_octet_sr_d;
    logic [2:0]            r_bit_cnt,      w_bit_cnt_d;
    logic [7:0]            r_oct_cnt,      w_oct_cnt_d;
    logic [7:0]            r_len,          w_len_d;
    logic                  r_len_err_pend, w_len_err_pend_d;
    logic [23:0]           r_crc,          w_crc_d;
    logic [23:0]           r_crc_rx,       w_crc_rx_d;
    logic [4:0]            r_crc_cnt,      w_crc_cnt_d;
    logic [GAP_WIDTH-1:0]  r_gap,          w_gap_d;
    logic [7:0]            r_octet,        w_octet_d;
    logic                  r_octet_valid,  w_octet_valid_d;
    logic                  r_sop,          w_sop_d;
    logic                  r_eop,          w_eop_d;
    logic [LEN_WIDTH-1:0]  r_plen,         w_plen_d;
    logic                  r_plv,          w_plv_d;
    logic                  r_decode_end,   w_decode_end_d;
    logic                  r_crc_ok,       w_crc_ok_d;
    logic                  r_len_error,    w_len_error_d;
    logic                  r_timeout,      w_timeout_d;

    logic [7:0]            w_sr_shift;
    logic [23:0]           w_crc_step;
    logic [23:0]           w_crc_rx_shift;
    logic [GAP_WIDTH-1:0]  w_gap_inc;
    logic                  w_adv_chan;
    logic [7:0]            w_len;

    assign w_sr_shift     = {info_bit, r_octet_sr[7:1]};
    assign w_crc_step     = {r_crc[22:0], 1'b0} ^ ((r_crc[23] ^ info_bit) ? CRC_POLY : 24'h0);
    assign w_crc_rx_shift = {r_crc_rx[22:0], info_bit};
    assign w_gap_inc      = r_gap + GAP_WIDTH'(1);
    assign w_adv_chan     = (32'(channel_number) >= 32'd37) && (32'(channel_number) <= 32'd39);

    // Length field width depends on PDU type: advertising, extended data, or legacy data.
    always_comb begin
        if (w_adv_chan) begin
            w_len = {2'b00, w_sr_shift[5:0]};
        end else if (ext_len_en) begin
            w_len = w_sr_shift;
        end else begin
            w_len = {3'b000, w_sr_shift[4:0]};
        end
    end

    always_comb begin
        w_state_d        = r_state;
        w_octet_sr_d     = r_octet_sr;
        w_bit_cnt_d      = r_bit_cnt;
        w_oct_cnt_d      = r_oct_cnt;
        w_len_d          = r_len;
        w_len_err_pend_d = r_len_err_pend;
        w_crc_d          = r_crc;
        w_crc_rx_d       = r_crc_rx;
        w_crc_cnt_d      = r_crc_cnt;
        w_gap_d          = r_gap;
        w_octet_d        = r_octet;
        w_octet_valid_d  = 1'b0;
        w_sop_d          = 1'b0;
        w_eop_d          = 1'b0;
        w_plen_d         = r_plen;
        w_plv_d          = 1'b0;
        w_decode_end_d   = 1'b0;
        w_crc_ok_d       = r_crc_ok;
        w_len_error_d    = r_len_error;
        w_timeout_d      = r_timeout;

        if (hit_flag) begin
            // A new hit always restarts the frame, silently dropping any packet in flight.
            w_state_d        = StHeader;
            w_crc_d          = crc_state_init_bit;
            w_bit_cnt_d      = '0;
            w_oct_cnt_d      = '0;
            w_len_d          = '0;
            w_len_err_pend_d = 1'b0;
            w_crc_rx_d       = '0;
            w_crc_cnt_d      = '0;
            w_gap_d          = '0;
            w_plen_d         = '0;
            w_crc_ok_d       = 1'b0;
            w_len_error_d    = 1'b0;
            w_timeout_d      = 1'b0;
        end else if (r_state != StIdle) begin
            w_gap_d = w_gap_inc;
            if (r_len_err_pend) begin
                w_len_err_pend_d = 1'b0;
                w_len_error_d    = 1'b1;
                w_decode_end_d   = 1'b1;
                w_state_d        = StIdle;
                w_gap_d          = '0;
            end else if (bit_valid) begin
                w_gap_d      = '0;
                w_octet_sr_d = w_sr_shift;
                w_bit_cnt_d  = r_bit_cnt + 3'd1;
                if (r_state == StCrc) begin
                    w_crc_rx_d  = w_crc_rx_shift;
                    w_crc_cnt_d = r_crc_cnt + 5'd1;
                    if (r_crc_cnt == 5'd23) begin
                        w_decode_end_d = 1'b1;
                        w_crc_ok_d     = (w_crc_rx_shift == r_crc);
                        w_state_d      = StIdle;
                    end
                end else begin
                    w_crc_d = w_crc_step;
                    if (r_bit_cnt == 3'd7) begin
                        w_octet_d       = w_sr_shift;
                        w_octet_valid_d = 1'b1;
                        w_oct_cnt_d     = r_oct_cnt + 8'd1;
                        if (r_state == StHeader && r_oct_cnt == 8'd0) begin
                            w_sop_d = 1'b1;
                        end else if (r_state == StHeader) begin
                            w_len_d     = w_len;
                            w_plen_d    = LEN_WIDTH'(w_len);
                            w_plv_d     = 1'b1;
                            w_oct_cnt_d = '0;
                            if (32'(w_len) > MAX_PAYLOAD_LEN) begin
                                w_len_err_pend_d = 1'b1;
                            end else if (w_len == 8'd0) begin
                                w_eop_d   = 1'b1;
                                w_state_d = StCrc;
                            end else begin
                                w_state_d = StPayload;
                            end
                        end else if (r_oct_cnt + 8'd1 == r_len) begin
                            w_eop_d   = 1'b1;
                            w_state_d = StCrc;
                        end
                    end
                end
            end else if (32'(w_gap_inc) == TIMEOUT_CYCLES) begin
                w_timeout_d    = 1'b1;
                w_decode_end_d = 1'b1;
                w_state_d      = StIdle;
                w_gap_d        = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_octet_sr     <= '0;
            r_bit_cnt      <= '0;
            r_oct_cnt      <= '0;
            r_len          <= '0;
            r_len_err_pend <= 1'b0;
            r_crc          <= crc_state_init_bit;
            r_crc_rx       <= '0;
            r_crc_cnt      <= '0;
            r_gap          <= '0;
            r_octet        <= '0;
            r_octet_valid  <= 1'b0;
            r_sop          <= 1'b0;
            r_eop          <= 1'b0;
            r_plen         <= '0;
            r_plv          <= 1'b0;
            r_decode_end   <= 1'b0;
            r_crc_ok       <= 1'b0;
            r_len_error    <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_octet_sr     <= w_octet_sr_d;
            r_bit_cnt      <= w_bit_cnt_d;
            r_oct_cnt      <= w_oct_cnt_d;
            r_len          <= w_len_d;
            r_len_err_pend <= w_len_err_pend_d;
            r_crc          <= w_crc_d;
            r_crc_rx       <= w_crc_rx_d;
            r_crc_cnt      <= w_crc_cnt_d;
            r_gap          <= w_gap_d;
            r_octet        <= w_octet_d;
            r_octet_valid  <= w_octet_valid_d;
            r_sop          <= w_sop_d;
            r_eop          <= w_eop_d;
            r_plen         <= w_plen_d;
            r_plv          <= w_plv_d;
            r_decode_end   <= w_decode_end_d;
            r_crc_ok       <= w_crc_ok_d;
            r_len_error    <= w_len_error_d;
            r_timeout      <= w_timeout_d;
        end
    end

    assign octet                = r_octet;
    assign octet_valid          = r_octet_valid;
    assign octet_sop            = r_sop;
    assign octet_eop            = r_eop;
    assign payload_length       = r_plen;
    assign payload_length_valid = r_plv;
    assign busy                 = (r_state != StIdle);
    assign decode_end           = r_decode_end;
    assign crc_ok               = r_crc_ok;
    assign length_error         = r_len_error;
    assign timeout              = r_timeout;

endmodule

// File: doc/btle_rx_frame_ctrl.md
BTLE_RX_FRAME_CTRL -- requirements
Module: btle_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 8: width of the payload_length output; the legal range is 6..8.
REQ-002 SHALL have parameter MAX_PAYLOAD_LEN, default 255: the largest accepted payload length; longer lengths abort the packet.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of clk cycles allowed between bit_valid pulses while a packet is in progress.
REQ-004 SHALL have parameter CHANNEL_NUMBER_BIT_WIDTH, default 6: width of channel_number.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-006 Port list (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- channel_number  in  CHANNEL_NUMBER_BIT_WIDTH  BLE channel index.
- ext_len_en  in  1  data-channel length-extension mode.
- crc_state_init_bit  in  24  CRC preset.
- hit_flag  in  1  access-address match pulse.
- info_bit  in  1  descrambled bit.
- bit_valid  in  1  info_bit qualifier.
- octet  out  8  assembled octet.
- octet_valid  out  1  octet strobe.
- octet_sop  out  1  first-header-octet marker.
- octet_eop  out  1  last-octet marker.
- payload_length  out  LEN_WIDTH  parsed payload length.
- payload_length_valid  out  1  length strobe.
- busy  out  1  packet in progress.
- decode_end  out  1  end-of-packet strobe.
- crc_ok  out  1  CRC status.
- length_error  out  1  length status.
- timeout  out  1  timeout status.

Function
REQ-007 SHALL implement the states IDLE, HEADER, PAYLOAD and CRC; busy=1 in every state except IDLE.
REQ-008 IDLE SHALL transition to HEADER on hit_flag=1; the bit_valid in the same cycle as hit_flag SHALL be ignored.
REQ-009 On hit_flag, the block SHALL:
- preset the CRC register to crc_state_init_bit;
- clear the bit counter;
- clear crc_ok, length_error and timeout.
REQ-010 Bits SHALL arrive LSB first; on each bit_valid the octet shift register SHALL update as octet_sr <= {info_bit, octet_sr[7:1]}.
REQ-011 The CRC SHALL be updated only in HEADER and PAYLOAD, with fb = c[23]^info_bit and c <= {c[22:0],1'b0} ^ (fb ? 24'h00065B : 0).
REQ-012 Every header and payload octet SHALL be presented on octet, with octet_valid=1 for exactly one cycle, in the cycle after the cycle that samples its 8th bit; CRC octets SHALL NOT be output.
REQ-013 octet_sop SHALL be 1 with header octet 0; octet_eop SHALL be 1 with the last payload octet, or with header octet 1 when the length is 0.
REQ-014 When header octet 1 completes, the length SHALL be extracted as follows:
- advertising channels (channel_number 37..39): L = octet1[5:0];
- otherwise with ext_len_en=1: L = octet1[7:0];
- otherwise: L = octet1[4:0].
L SHALL be zero-extended to LEN_WIDTH.
REQ-015 payload_length SHALL take L, with payload_length_valid=1 for one cycle, coincident with octet_valid for header octet 1.
REQ-016 After the length is extracted:
- L > MAX_PAYLOAD_LEN: length_error=1, decode_end pulse, go to IDLE;
- L = 0: go to CRC;
- otherwise: go to PAYLOAD.
REQ-017 PAYLOAD SHALL count L octets and then go to CRC with the CRC register frozen.
REQ-018 CRC SHALL shift the 24 received bits as crc_rx <= {crc_rx[22:0], info_bit}.
REQ-019 After the 24th CRC bit, the next cycle SHALL give decode_end=1 for one cycle and crc_ok = (crc_rx == c), then return to IDLE.
REQ-020 Gap counter:
- resets on every bit_valid and on hit_flag;
- increments each cycle while busy.
REQ-021 When the gap counter reaches TIMEOUT_CYCLES, the block SHALL set timeout=1, pulse decode_end, return to IDLE, and leave crc_ok=0.
REQ-022 crc_ok, length_error and timeout SHALL hold their value from decode_end until the next hit_flag or reset.
REQ-023 hit_flag while busy SHALL restart HEADER with no decode_end for the discarded packet; it takes priority over bit_valid, a timeout in the same cycle, and completion.
REQ-024 payload_length SHALL hold its value until the next hit_flag clears it to 0.

Reset
REQ-025 While rst=1, the block SHALL go to IDLE and drive all outputs, octet_sr, the counters and crc_rx to 0; the CRC register SHALL be loaded with crc_state_init_bit.
REQ-026 rst SHALL take priority over hit_flag and bit_valid; rst in the middle of a packet SHALL abort it silently, with no decode_end.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Scenario 1: channel 37, header 0x02 0x06, 6 payload octets, correct CRC from the model -> 8 octet_valid strobes, sop on 0x02, eop on payload octet 6, payload_length=6, decode_end with crc_ok=1.
- Scenario 2: the same packet with one payload bit flipped -> 8 octets still output, decode_end with crc_ok=0.
- Scenario 3: channel 5, ext_len_en=1, header octet1=0xFB, MAX_PAYLOAD_LEN=255 -> payload_length=251, 253 octets output, crc_ok=1; with ext_len_en=0 on the same header -> length 27 is parsed.
- Scenario 4: MAX_PAYLOAD_LEN=37, channel 38, octet1=0x3F -> payload_length=63, length_error=1, decode_end 1 cycle after payload_length_valid, no payload octets.
- Scenario 5: bit_valid stops after 12 payload bits, TIMEOUT_CYCLES=64 -> decode_end and timeout=1 exactly 64 cycles after the last bit_valid, crc_ok=0.
- Scenario 6: a second hit_flag in the middle of the payload, then a full valid packet -> no decode_end for the first packet, sop again, crc_ok=1 for the second; rst asserted mid-packet -> all outputs 0 the next cycle.
